// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write arbiter.
//   state_e   : arbiter FSM states (IDLE, GRANT)
//   cnt_width : width of the per-grant beat counter for a given MAX_BURST
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Counter must hold 0..MAX_BURST-1; never narrower than one bit.
  function automatic int cnt_width(input int max_burst);
    return (max_burst <= 2) ? 1 : $clog2(max_burst);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_select.sv
// Combinational round-robin selector.
//   req_i  : request vector
//   ptr_i  : index holding highest priority this round
//   win_o  : one-hot winner (all-zero when no request)
//   idx_o  : binary index of the winner (0 when no request)
module rr_select #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic found;
  int   j;

  // Scan ptr, ptr+1, ... wrapping; first asserted request wins.
  always_comb begin
    win_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        win_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of an external FIFO.
// A winner owns the FIFO write port for up to MAX_BURST words, then the
// arbiter spends one IDLE cycle re-arbitrating.
//   clk, reset   : clock, asynchronous active-high reset
//   req          : per-requester level write request
//   req_data     : packed words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_full    : FIFO full flag (stalls the current owner)
//   fifo_wr      : FIFO write strobe
//   fifo_w_data  : FIFO write data (0 while idle)
//   grant        : one-hot current owner
//   ack          : one-hot pulse for the requester written this cycle
//   busy         : high while a grant is held
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          fifo_full,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_w_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          busy
);

  localparam int IDX_W = (NUM_REQ <= 2) ? 1 : $clog2(NUM_REQ);
  localparam int CNT_W = cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  state_e               state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [IDX_W-1:0]     ptr_d;
  logic [CNT_W-1:0]     cnt_q;

  logic [NUM_REQ-1:0]   win;
  logic [IDX_W-1:0]     win_idx;
  logic                 owner_req;
  logic                 last_beat;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req_i (req),
    .ptr_i (ptr_q),
    .win_o (win),
    .idx_o (win_idx)
  );

  // Priority moves to the requester after the winner.
  assign ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;

  // grant_q is all-zero in IDLE, so these collapse to 0 there.
  assign owner_req = |(req & grant_q);
  assign fifo_wr   = (state_q == GRANT) & owner_req & ~fifo_full;
  assign ack       = {NUM_REQ{fifo_wr}} & grant_q;
  assign grant     = grant_q;
  assign busy      = (state_q == GRANT);
  assign last_beat = (cnt_q == LAST_BEAT);

  always_comb begin
    fifo_w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) fifo_w_data = fifo_w_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= GRANT;
            grant_q <= win;
            ptr_q   <= ptr_d;
            cnt_q   <= '0;
          end
        end
        GRANT: begin
          // Owner dropping its request releases even while the FIFO is full.
          if (!owner_req || (fifo_wr && last_beat)) begin
            state_q <= IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
          end else if (fifo_wr) begin
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule
